// File: rtl/mult_seq_nxn_pkg.sv
// rtl/mult_seq_nxn_pkg.sv - shared types and size helpers for the sequential NxN multiplier
//   state_t     : control FSM states
//   calc_nstep  : number of digit-product steps for an operand width / digit width
//   calc_cw     : step counter width (minimum 1 bit)
//   digit_shift : bit position of the partial product of digits i (of a) and j (of b)
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic int calc_nstep(input int width, input int digit);
        return (width / digit) * (width / digit);
    endfunction

    function automatic int calc_cw(input int nstep);
        return (nstep <= 2) ? 1 : $clog2(nstep);
    endfunction

    function automatic int digit_shift(input int digit, input int i, input int j);
        return digit * (i + j);
    endfunction

endpackage

// File: rtl/mult_seq_nxn_if.sv
// rtl/mult_seq_nxn_if.sv - request/result bundle between a requester and mult_seq_nxn
//   start, signed_mode, dataa, datab : request side (master drives)
//   ready, busy, done, product       : status and result (slave drives)
interface mult_seq_nxn_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       dataa;
    logic [WIDTH-1:0]       datab;
    logic                   ready;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, signed_mode, dataa, datab,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, signed_mode, dataa, datab,
        output ready, busy, done, product
    );
endinterface

// File: rtl/mult_seq_nxn_digit_mult.sv
// rtl/mult_seq_nxn_digit_mult.sv - combinational DIGIT x DIGIT unsigned multiplier
//   a, b : DIGIT-bit unsigned digits
//   p    : 2*DIGIT-bit product
module digit_mult #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0]   a,
    input  logic [DIGIT-1:0]   b,
    output logic [2*DIGIT-1:0] p
);
    assign p = (2*DIGIT)'(a) * (2*DIGIT)'(b);
endmodule

// File: rtl/mult_seq_nxn.sv
// rtl/mult_seq_nxn.sv - sequential shift-and-add multiplier, one digit product per clock
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : mult_seq_nxn_if slave (start/signed_mode/dataa/datab in; ready/busy/done/product out)
module mult_seq_nxn
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIGIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    mult_seq_nxn_if.slave     bus
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int NSTEP = calc_nstep(WIDTH, DIGIT);
    localparam int CW    = calc_cw(NSTEP);
    localparam int PW    = 2 * WIDTH;

    state_t              state;
    logic [WIDTH-1:0]    a_mag;
    logic [WIDTH-1:0]    b_mag;
    logic                neg;
    logic [CW-1:0]       step;
    logic [PW-1:0]       acc;
    logic [PW-1:0]       product_q;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;

    // Magnitudes of the incoming operands. The most negative value negates to
    // itself, whose bit pattern is exactly the unsigned magnitude 2^(WIDTH-1).
    logic                a_is_neg;
    logic                b_is_neg;
    logic [WIDTH-1:0]    a_abs;
    logic [WIDTH-1:0]    b_abs;

    assign a_is_neg = bus.signed_mode & bus.dataa[WIDTH-1];
    assign b_is_neg = bus.signed_mode & bus.datab[WIDTH-1];
    assign a_abs    = a_is_neg ? (~bus.dataa + WIDTH'(1)) : bus.dataa;
    assign b_abs    = b_is_neg ? (~bus.datab + WIDTH'(1)) : bus.datab;

    // Digit selection: the step walks all digits of a for each digit of b.
    int                  i_idx;
    int                  j_idx;
    logic [DIGIT-1:0]    a_dig;
    logic [DIGIT-1:0]    b_dig;
    logic [2*DIGIT-1:0]  pp;
    logic [PW-1:0]       pp_shift;

    always_comb begin
        i_idx    = int'(step) % NDIG;
        j_idx    = int'(step) / NDIG;
        a_dig    = a_mag[i_idx*DIGIT +: DIGIT];
        b_dig    = b_mag[j_idx*DIGIT +: DIGIT];
        pp_shift = PW'(pp) << digit_shift(DIGIT, i_idx, j_idx);
    end

    digit_mult #(.DIGIT(DIGIT)) u_digit_mult (
        .a (a_dig),
        .b (b_dig),
        .p (pp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_mag     <= '0;
            b_mag     <= '0;
            neg       <= 1'b0;
            step      <= '0;
            acc       <= '0;
            product_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_mag   <= a_abs;
                        b_mag   <= b_abs;
                        neg     <= a_is_neg ^ b_is_neg;
                        acc     <= '0;
                        step    <= '0;
                        state   <= CALC;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                CALC: begin
                    acc <= acc + pp_shift;
                    if (step == CW'(NSTEP - 1)) begin
                        state <= FIN;
                    end else begin
                        step <= step + CW'(1);
                    end
                end
                FIN: begin
                    // A zero magnitude with neg set negates to zero, as required.
                    product_q <= neg ? (~acc + PW'(1)) : acc;
                    done_q    <= 1'b1;
                    state     <= IDLE;
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready   = ready_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_mult_seq_nxn.sv
// tb/tb_mult_seq_nxn.sv - self-checking bench for mult_seq_nxn at WIDTH=4 and WIDTH=8
module tb_mult_seq_nxn;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mult_seq_nxn_if #(.WIDTH(4)) b4();
    mult_seq_nxn_if #(.WIDTH(8)) b8();

    mult_seq_nxn #(.WIDTH(4), .DIGIT(2)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    mult_seq_nxn #(.WIDTH(8), .DIGIT(2)) dut8 (.clk(clk), .reset(reset), .bus(b8));

    // Reference: interpret operands as integers and multiply, keep 2*w bits.
    function automatic logic [15:0] ref_mul(input int w, input logic [7:0] a, input logic [7:0] b, input bit sm);
        longint av, bv, p, mask;
        mask = (longint'(1) << w) - 1;
        av = longint'(a) & mask;
        bv = longint'(b) & mask;
        if (sm && av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
        if (sm && bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
        p = av * bv;
        return 16'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic drive(input int w, input bit st, input bit sm, input logic [7:0] a, input logic [7:0] b);
        if (w == 4) begin
            b4.start = st; b4.signed_mode = sm; b4.dataa = a[3:0]; b4.datab = b[3:0];
        end else begin
            b8.start = st; b8.signed_mode = sm; b8.dataa = a; b8.datab = b;
        end
    endtask

    function automatic bit dut_done(input int w);
        return (w == 4) ? b4.done : b8.done;
    endfunction
    function automatic bit dut_ready(input int w);
        return (w == 4) ? b4.ready : b8.ready;
    endfunction
    function automatic bit dut_busy(input int w);
        return (w == 4) ? b4.busy : b8.busy;
    endfunction
    function automatic logic [15:0] dut_product(input int w);
        return (w == 4) ? {8'h00, b4.product} : b8.product;
    endfunction

    // Called at a negedge with the DUT able to accept. Returns the number of
    // edges from acceptance to done and whether ready/busy stayed in the busy
    // pattern throughout. Inputs are scrambled right after acceptance.
    task automatic op(input int w, input logic [7:0] a, input logic [7:0] b, input bit sm,
                      output logic [15:0] prod, output int cyc, output bit hs_ok);
        drive(w, 1'b1, sm, a, b);
        @(negedge clk);
        drive(w, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
        cyc = 0;
        hs_ok = 1'b1;
        while (!dut_done(w) && cyc < 100) begin
            if (dut_ready(w) || !dut_busy(w)) hs_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        prod = dut_product(w);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(4, 1'b1, 1'b0, 8'd3, 8'd3);
        drive(8, 1'b1, 1'b0, 8'd3, 8'd3);
        repeat (3) @(negedge clk);
        n_checks++; if (b4.ready !== 1'b1) $display("FAIL reset_ready4: got %b want 1", b4.ready); else n_pass++;
        n_checks++; if (b4.busy !== 1'b0) $display("FAIL reset_busy4: got %b want 0", b4.busy); else n_pass++;
        n_checks++; if (b4.done !== 1'b0) $display("FAIL reset_done4: got %b want 0", b4.done); else n_pass++;
        n_checks++; if (b4.product !== 8'h00) $display("FAIL reset_product4: got %h want 00", b4.product); else n_pass++;
        n_checks++; if (b8.ready !== 1'b1 || b8.busy !== 1'b0 || b8.done !== 1'b0)
            $display("FAIL reset_status8: got r%b b%b d%b want r1 b0 d0", b8.ready, b8.busy, b8.done); else n_pass++;
        n_checks++; if (b8.product !== 16'h0000) $display("FAIL reset_product8: got %h want 0000", b8.product); else n_pass++;
        drive(4, 1'b0, 1'b0, 8'd0, 8'd0);
        drive(8, 1'b0, 1'b0, 8'd0, 8'd0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned_max();
        logic [15:0] p; int cyc; bit hs;
        op(4, 8'd15, 8'd15, 1'b0, p, cyc, hs);
        n_checks++; if (p !== 16'd225) $display("FAIL u15x15: got %0d want 225", p); else n_pass++;
        n_checks++; if (cyc !== 5) $display("FAIL u15x15_latency: got %0d want 5", cyc); else n_pass++;
        n_checks++; if (hs !== 1'b1) $display("FAIL u15x15_handshake: ready/busy wrong while running"); else n_pass++;
        n_checks++; if (b4.ready !== 1'b1) $display("FAIL u15x15_ready_done: got %b want 1", b4.ready); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (b4.done !== 1'b0) $display("FAIL done_single_pulse: got %b want 0", b4.done); else n_pass++;
        n_checks++; if (b4.product !== 8'hE1) $display("FAIL product_held: got %h want e1", b4.product); else n_pass++;
    endtask

    task automatic test_signed();
        logic [7:0] ta [4] = '{8'h8, 8'h8, 8'h0, 8'h5};
        logic [7:0] tb [4] = '{8'h8, 8'h7, 8'hD, 8'hF};
        logic [7:0] te [4] = '{8'h40, 8'hC8, 8'h00, 8'hFB};
        logic [15:0] p; int cyc; bit hs;
        for (int k = 0; k < 4; k++) begin
            op(4, ta[k], tb[k], 1'b1, p, cyc, hs);
            n_checks++; if (p[7:0] !== te[k]) $display("FAIL signed4_%0d: got %h want %h", k, p[7:0], te[k]); else n_pass++;
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        drive(4, 1'b1, 1'b0, 8'd6, 8'd7);
        @(negedge clk);
        cyc = 0;
        while (!b4.done && cyc < 100) begin
            drive(4, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (b4.product !== 8'd42) $display("FAIL ignore_start: got %0d want 42", b4.product); else n_pass++;
        n_checks++; if (cyc !== 5) $display("FAIL ignore_start_latency: got %0d want 5", cyc); else n_pass++;
        // Start held in the done cycle: accepted with no gap.
        drive(4, 1'b1, 1'b0, 8'd9, 8'd5);
        @(negedge clk);
        n_checks++; if (b4.ready !== 1'b0 || b4.done !== 1'b0)
            $display("FAIL back_to_back_accept: got r%b d%b want r0 d0", b4.ready, b4.done); else n_pass++;
        drive(4, 1'b0, 1'b1, 8'd1, 8'd1);
        cyc = 0;
        while (!b4.done && cyc < 100) begin @(negedge clk); cyc++; end
        n_checks++; if (b4.product !== 8'd45) $display("FAIL back_to_back: got %0d want 45", b4.product); else n_pass++;
        n_checks++; if (cyc !== 5) $display("FAIL back_to_back_latency: got %0d want 5", cyc); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [15:0] p; int cyc; bit hs; bit saw_done;
        drive(4, 1'b1, 1'b0, 8'd5, 8'd5);
        @(negedge clk);
        drive(4, 1'b0, 1'b0, 8'd0, 8'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        drive(4, 1'b1, 1'b0, 8'd7, 8'd7);
        @(negedge clk);
        reset = 1'b0;
        drive(4, 1'b0, 1'b0, 8'd0, 8'd0);
        n_checks++; if (b4.product !== 8'h00) $display("FAIL reset_mid_product: got %h want 00", b4.product); else n_pass++;
        n_checks++; if (b4.done !== 1'b0 || b4.ready !== 1'b1 || b4.busy !== 1'b0)
            $display("FAIL reset_mid_status: got r%b b%b d%b want r1 b0 d0", b4.ready, b4.busy, b4.done); else n_pass++;
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (b4.done) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) $display("FAIL reset_mid_no_done: got done pulse want none"); else n_pass++;
        op(4, 8'd3, 8'd3, 1'b0, p, cyc, hs);
        n_checks++; if (p !== 16'd9) $display("FAIL after_reset_3x3: got %0d want 9", p); else n_pass++;
    endtask

    task automatic test_width8();
        logic [15:0] p; int cyc; bit hs;
        op(8, 8'd255, 8'd255, 1'b0, p, cyc, hs);
        n_checks++; if (p !== 16'd65025) $display("FAIL w8_255x255: got %0d want 65025", p); else n_pass++;
        n_checks++; if (cyc !== 17) $display("FAIL w8_latency: got %0d want 17", cyc); else n_pass++;
        n_checks++; if (hs !== 1'b1) $display("FAIL w8_handshake: ready/busy wrong while running"); else n_pass++;
        op(8, 8'h80, 8'h80, 1'b1, p, cyc, hs);
        n_checks++; if (p !== 16'd16384) $display("FAIL w8_m128xm128: got %h want 4000", p); else n_pass++;
        op(8, 8'h80, 8'h7F, 1'b1, p, cyc, hs);
        n_checks++; if (p !== 16'hC080) $display("FAIL w8_m128x127: got %h want c080", p); else n_pass++;
    endtask

    task automatic test_sweep();
        logic [15:0] p; int cyc; bit hs; logic [7:0] a, b; bit sm;
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 256; x++) begin
                a = 8'(x & 15);
                b = 8'(x >> 4);
                op(4, a, b, m[0], p, cyc, hs);
                n_checks++;
                if (p !== ref_mul(4, a, b, m[0]) || cyc !== 5 || !hs)
                    $display("FAIL sweep4 a=%0d b=%0d s=%0d: got %h lat %0d want %h lat 5", a, b, m, p, cyc, ref_mul(4, a, b, m[0]));
                else n_pass++;
            end
        end
        for (int k = 0; k < 1000; k++) begin
            a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
            op(8, a, b, sm, p, cyc, hs);
            n_checks++;
            if (p !== ref_mul(8, a, b, sm) || cyc !== 17 || !hs)
                $display("FAIL sweep8 a=%h b=%h s=%0d: got %h lat %0d want %h lat 17", a, b, sm, p, cyc, ref_mul(8, a, b, sm));
            else n_pass++;
        end
        @(negedge clk);
        repeat (20) begin
            @(negedge clk);
            n_checks++;
            if (b4.done !== 1'b0 || b8.done !== 1'b0) $display("FAIL idle_no_done: got d4=%b d8=%b want 0", b4.done, b8.done);
            else n_pass++;
        end
    endtask

    initial begin
        drive(4, 1'b0, 1'b0, 8'd0, 8'd0);
        drive(8, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        test_reset();
        test_unsigned_max();
        test_signed();
        test_start_while_busy();
        test_reset_mid();
        test_width8();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
